// File: rtl/branch_predictor_2bit_pkg.sv
// Shared types for the fetch-stage branch target buffer.
package bp_pkg;

    localparam int unsigned XLEN = 32;

    // Opcode class of control-transfer instructions (op_ex[6:4]).
    localparam logic [2:0] OP_CTRL = 3'b110;

    // Tag field sized for the smallest legal table (ENTRIES=2); larger tables zero-extend.
    localparam int unsigned TAG_MAX_W = XLEN - 3;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [XLEN-1:0]      target;
        ctr_t                 ctr;
    } btb_entry_t;

    function automatic int unsigned tag_w(input int unsigned entries);
        return XLEN - 2 - $clog2(entries);
    endfunction

endpackage

// File: rtl/branch_predictor_2bit_if.sv
// Fetch lookup, EX resolution and performance-counter signals of the predictor.
interface bp_if;
    import bp_pkg::*;

    logic [XLEN-1:0] pc_IF_i;
    logic            stall_i;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic            upd_taken_i;
    logic [XLEN-1:0] upd_target_i;
    logic            mispredict_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic [XLEN-1:0] next_pc_o;
    logic [XLEN-1:0] br_cnt_o;
    logic [XLEN-1:0] miss_cnt_o;

    modport master (
        output pc_IF_i, stall_i, upd_valid_i, upd_pc_i, upd_taken_i,
               upd_target_i, mispredict_i, redirect_pc_i,
        input  pred_taken_o, pred_target_o, next_pc_o, br_cnt_o, miss_cnt_o
    );

    modport slave (
        input  pc_IF_i, stall_i, upd_valid_i, upd_pc_i, upd_taken_i,
               upd_target_i, mispredict_i, redirect_pc_i,
        output pred_taken_o, pred_target_o, next_pc_o, br_cnt_o, miss_cnt_o
    );

endinterface

// File: rtl/branch_predictor_2bit_sat_ctr2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_ctr2
    import bp_pkg::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    output ctr_t ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        unique case (ctr_i)
            SNT: ctr_o = taken_i ? WNT : SNT;
            WNT: ctr_o = taken_i ? WT  : SNT;
            WT:  ctr_o = taken_i ? ST  : WNT;
            ST:  ctr_o = taken_i ? ST  : WT;
            default: ctr_o = ctr_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor_2bit.sv
// Direct-mapped BTB with 2-bit counters: combinational next-PC lookup,
// EX-stage training and saturating branch/mispredict counters.
module branch_predictor_2bit
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    bp_if.slave  bp
);

    localparam int unsigned IDX = $clog2(ENTRIES);

    btb_entry_t btb_q [ENTRIES];
    btb_entry_t btb_d [ENTRIES];

    logic [XLEN-1:0] br_cnt_q, br_cnt_d;
    logic [XLEN-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX-1:0]       lk_idx;
    logic [TAG_MAX_W-1:0] lk_tag;
    btb_entry_t           lk_entry;
    logic                 lk_hit;

    logic [IDX-1:0]       up_idx;
    logic [TAG_MAX_W-1:0] up_tag;
    btb_entry_t           up_entry;
    logic                 up_hit;
    ctr_t                 up_ctr_nxt;

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bp.pc_IF_i[1:0], bp.upd_pc_i[1:0]};

    // Fetch-side lookup sees only the registered table (pre-update contents).
    always_comb begin
        lk_idx   = bp.pc_IF_i[IDX+1:2];
        lk_tag   = TAG_MAX_W'(bp.pc_IF_i[XLEN-1:IDX+2]);
        lk_entry = btb_q[lk_idx];
        lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
    end

    assign bp.pred_taken_o  = lk_hit && lk_entry.ctr[1];
    assign bp.pred_target_o = lk_hit ? lk_entry.target : '0;

    always_comb begin
        if (bp.mispredict_i) begin
            bp.next_pc_o = bp.redirect_pc_i;
        end else if (bp.stall_i) begin
            bp.next_pc_o = bp.pc_IF_i;
        end else if (bp.pred_taken_o) begin
            bp.next_pc_o = bp.pred_target_o;
        end else begin
            bp.next_pc_o = bp.pc_IF_i + XLEN'(4);
        end
    end

    always_comb begin
        up_idx   = bp.upd_pc_i[IDX+1:2];
        up_tag   = TAG_MAX_W'(bp.upd_pc_i[XLEN-1:IDX+2]);
        up_entry = btb_q[up_idx];
        up_hit   = up_entry.valid && (up_entry.tag == up_tag);
    end

    sat_ctr2 u_sat_ctr2 (
        .ctr_i   (up_entry.ctr),
        .taken_i (bp.upd_taken_i),
        .ctr_o   (up_ctr_nxt)
    );

    // Training: hits move the counter, taken misses (re)allocate at WT.
    always_comb begin
        btb_d = btb_q;
        if (bp.upd_valid_i) begin
            if (up_hit) begin
                btb_d[up_idx].ctr = up_ctr_nxt;
                if (bp.upd_taken_i) begin
                    btb_d[up_idx].target = bp.upd_target_i;
                end
            end else if (bp.upd_taken_i) begin
                btb_d[up_idx].valid  = 1'b1;
                btb_d[up_idx].tag    = up_tag;
                btb_d[up_idx].target = bp.upd_target_i;
                btb_d[up_idx].ctr    = WT;
            end
        end
    end

    always_comb begin
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (bp.upd_valid_i && (br_cnt_q != '1)) begin
            br_cnt_d = br_cnt_q + XLEN'(1);
        end
        if (bp.upd_valid_i && bp.mispredict_i && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                btb_q[i].valid  <= 1'b0;
                btb_q[i].tag    <= '0;
                btb_q[i].target <= '0;
                btb_q[i].ctr    <= WNT;
            end
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            btb_q      <= btb_d;
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bp.br_cnt_o   = br_cnt_q;
    assign bp.miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor_2bit.sv
// Randomized scoreboard bench for branch_predictor_2bit against an array-based reference model.
module tb_branch_predictor_2bit;
    import bp_pkg::*;

    localparam int unsigned ENTRIES = 32;
    localparam int unsigned IDX     = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bp_if bp ();

    branch_predictor_2bit #(.ENTRIES(ENTRIES)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bp     (bp)
    );

    typedef struct {
        string       name;
        logic        pt;
        logic [31:0] ptgt;
        logic [31:0] npc;
        logic [31:0] br;
        logic [31:0] miss;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: plain arrays, counter strength as an integer 0..3.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_br, m_miss;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (IDX + 2);
    endfunction

    task automatic check(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%h required=%h t=%0t", name, field, act, req, $time);
        end
    endtask

    task automatic model_edge();
        int i;
        if (!rst_n) begin
            for (int k = 0; k < int'(ENTRIES); k++) begin
                m_valid[k] = 1'b0; m_tag[k] = '0; m_tgt[k] = '0; m_ctr[k] = 1;
            end
            m_br = '0; m_miss = '0;
        end else if (bp.upd_valid_i) begin
            if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
            if (bp.mispredict_i && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
            i = idx_of(bp.upd_pc_i);
            if (m_valid[i] && m_tag[i] == tag_of(bp.upd_pc_i)) begin
                if (bp.upd_taken_i) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_tgt[i] = bp.upd_target_i;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (bp.upd_taken_i) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(bp.upd_pc_i);
                m_tgt[i]   = bp.upd_target_i;
                m_ctr[i]   = 2;
            end
        end
    endtask

    // Push the expected response for the inputs now applied, then advance one edge.
    task automatic step(input string name, input bit chk);
        exp_t e;
        int   i;
        bit   hit;
        i      = idx_of(bp.pc_IF_i);
        hit    = m_valid[i] && (m_tag[i] == tag_of(bp.pc_IF_i));
        e.name = name;
        e.pt   = hit && (m_ctr[i] >= 2);
        e.ptgt = hit ? m_tgt[i] : 32'h0;
        if (bp.mispredict_i)  e.npc = bp.redirect_pc_i;
        else if (bp.stall_i)  e.npc = bp.pc_IF_i;
        else if (e.pt)        e.npc = e.ptgt;
        else                  e.npc = bp.pc_IF_i + 32'd4;
        e.br   = m_br;
        e.miss = m_miss;
        if (chk) q.push_back(e);
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic idle(input logic [31:0] pc);
        bp.pc_IF_i = pc; bp.stall_i = 1'b0; bp.upd_valid_i = 1'b0;
        bp.upd_pc_i = '0; bp.upd_taken_i = 1'b0; bp.upd_target_i = '0;
        bp.mispredict_i = 1'b0; bp.redirect_pc_i = '0;
    endtask

    task automatic upd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        bp.upd_valid_i = 1'b1; bp.upd_pc_i = pc; bp.upd_taken_i = taken; bp.upd_target_i = tgt;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        r = $urandom;
        if (r[31:27] == 5'd0) return 32'hFFFF_FFFC;
        return (32'(r[3:2]) << 7) | (32'(r[6:4]) << 2) | 32'(r[1:0]);
    endfunction

    // Monitor: compare every pushed expectation mid-cycle, away from the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.name, "pred_taken", 32'(bp.pred_taken_o), 32'(e.pt));
                check(e.name, "pred_target", bp.pred_target_o, e.ptgt);
                check(e.name, "next_pc", bp.next_pc_o, e.npc);
                check(e.name, "br_cnt", bp.br_cnt_o, e.br);
                check(e.name, "miss_cnt", bp.miss_cnt_o, e.miss);
            end
        end
    end

    initial begin
        logic [31:0] r;
        rst_n = 1'b0;
        idle(32'h100);
        step("rst0", 1'b0);
        step("rst1", 1'b1);
        rst_n = 1'b1;
        step("lookup_after_reset", 1'b1);

        upd(32'h100, 1'b1, 32'h180);
        step("alloc_upd", 1'b1);
        idle(32'h100);
        step("alloc_hit", 1'b1);

        upd(32'h100, 1'b0, 32'h0);  step("hyst_nt1", 1'b1);
        idle(32'h100);              step("hyst_wnt", 1'b1);
        upd(32'h100, 1'b1, 32'h180); step("hyst_t1", 1'b1);
        upd(32'h100, 1'b1, 32'h180); step("hyst_t2", 1'b1);
        upd(32'h100, 1'b0, 32'h0);  step("hyst_nt2", 1'b1);
        idle(32'h100);              step("hyst_wt", 1'b1);

        upd(32'h180, 1'b1, 32'h300); step("alias_upd", 1'b1);
        idle(32'h100);               step("alias_miss", 1'b1);
        idle(32'h180);               step("alias_hit", 1'b1);
        upd(32'h180, 1'b0, 32'h0);   step("alias_nt", 1'b1);
        idle(32'h180);               step("alias_wnt", 1'b1);

        upd(32'h100, 1'b1, 32'h180); step("prio_train", 1'b1);
        idle(32'h100);
        bp.mispredict_i = 1'b1; bp.redirect_pc_i = 32'h200; bp.stall_i = 1'b1;
        upd(32'h100, 1'b1, 32'h180);
        step("prio_redirect", 1'b1);
        idle(32'h100); bp.stall_i = 1'b1;
        step("prio_stall", 1'b1);
        idle(32'h100); bp.mispredict_i = 1'b1; bp.redirect_pc_i = 32'h444;
        step("misp_no_upd", 1'b1);
        idle(32'h100); step("misp_no_upd_cnt", 1'b1);

        idle(32'hFFFF_FFFC); step("pc_wrap", 1'b1);

        for (int n = 0; n < 1500; n++) begin
            r = $urandom;
            rst_n = (r[7:0] != 8'd0);
            bp.pc_IF_i       = rand_pc();
            bp.stall_i       = (r[10:9] == 2'd0);
            bp.upd_valid_i   = r[11];
            bp.upd_pc_i      = rand_pc();
            bp.upd_taken_i   = (r[14:12] > 3'd2);
            bp.upd_target_i  = $urandom;
            bp.mispredict_i  = (r[17:15] < 3'd2);
            bp.redirect_pc_i = $urandom;
            step("random", 1'b1);
        end
        rst_n = 1'b1;

        idle(32'h100); step("pre_sat", 1'b1);
        force dut.br_cnt_q   = 32'hFFFF_FFFE;
        force dut.miss_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.br_cnt_q;
        release dut.miss_cnt_q;
        m_br = 32'hFFFF_FFFE; m_miss = 32'hFFFF_FFFE;
        for (int n = 0; n < 3; n++) begin
            idle(32'h100); upd(32'h140, 1'b1, 32'h10); bp.mispredict_i = 1'b1;
            bp.redirect_pc_i = 32'h10;
            step("sat", 1'b1);
        end
        idle(32'h100); step("sat_hold", 1'b1);

        rst_n = 1'b0;
        idle(32'h100); upd(32'h100, 1'b1, 32'h180);
        step("rst_with_upd", 1'b1);
        rst_n = 1'b1;
        idle(32'h100); step("rst_cleared", 1'b1);
        idle(32'h140); step("rst_cleared2", 1'b1);

        @(posedge clk); #2;
        check("drain", "queue_left", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
